dualport_ram_cq: RTL and testbench

Parametrised dual-port RAM with a bounded conflict-resolution write queue, read forwarding from pending writes and write backpressure. It is the next-generation shared-memory block between two independent agents, such as a CPU and a DMA engine, on one clock. Writes that collide on one address, or that arrive while earlier writes are still pending, are serialised through a FIFO and committed one per cycle in a configurable priority order. Reads stay combinational and always return the youngest value written.

---
 rtl/dualport_ram_cq.sv | 161 ++++++++++++++++
 tb/tb_dualport_ram_cq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_ram_cq.sv
// Dual-port RAM shared by two agents on one clock. Colliding or
// late-arriving writes are serialised through a small FIFO and committed
// one per cycle; reads forward from the youngest pending write.
module dualport_ram_cq #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 11,
   parameter int Q_DEPTH   = 4,
   parameter int PRIO_MODE = 0,
   localparam int CNT_W    = $clog2(Q_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en_a,
   input  logic              wr_en_b,
   input  logic              rd_en_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wr_data_a,
   input  logic [DATA_W-1:0] wr_data_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              wr_ready_a,
   output logic              wr_ready_b,
   output logic              wr_ack_a,
   output logic              wr_ack_b,
   output logic [CNT_W-1:0]  q_count,
   output logic              wr_drop
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              port;   // 0 = port A, 1 = port B
   } entry_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(Q_DEPTH - 2);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   entry_t            q     [Q_DEPTH];   // q[0] is the head (oldest)
   entry_t            q_nxt [Q_DEPTH];
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  base;
   logic              live;          // low until the first edge after reset release
   logic              prio_b_first;  // conflict order toggle (PRIO_MODE 1)
   logic              ready;
   logic              acc_a, acc_b, conflict, pop, direct_a, direct_b;
   entry_t            ent_a, ent_b, push_first, push_second;
   logic [1:0]        n_push;

   // Room for two pushes is always guaranteed while ready is high; holding
   // ready low for the first cycle after reset keeps every output quiet then.
   assign ready      = live && (q_count <= READY_MAX);
   assign wr_ready_a = ready;
   assign wr_ready_b = ready;

   assign acc_a    = wr_en_a && ready;
   assign acc_b    = wr_en_b && ready;
   assign conflict = acc_a && acc_b && (addr_a == addr_b);
   assign pop      = (q_count != '0);
   // Direct commits only happen on an empty queue, so they never coincide
   // with a pop and each port gets at most one commit per edge.
   assign direct_a = acc_a && !pop && !conflict;
   assign direct_b = acc_b && !pop && !conflict;

   assign ent_a = '{addr: addr_a, data: wr_data_a, port: PORT_A};
   assign ent_b = '{addr: addr_b, data: wr_data_b, port: PORT_B};

   // Choose which accepted writes enter the queue and in what order.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      push_first  = ent_a;
      push_second = ent_b;
      n_push      = 2'd0;
      if (conflict) begin
         n_push = 2'd2;
         if (PRIO_MODE == 1 && prio_b_first) begin
            push_first  = ent_b;
            push_second = ent_a;
         end
      end else if (pop) begin
         if (acc_a && acc_b) begin
            n_push = 2'd2;
         end else if (acc_a) begin
            n_push = 2'd1;
         end else if (acc_b) begin
            n_push     = 2'd1;
            push_first = ent_b;
         end
      end
   end

   // Next queue image: shift out the head on a pop, append pushes behind it.
   always_comb begin
      base = q_count - CNT_W'(pop);
      for (int i = 0; i < Q_DEPTH - 1; i++) begin
         q_nxt[i] = pop ? q[i+1] : q[i];
      end
      q_nxt[Q_DEPTH-1] = pop ? '0 : q[Q_DEPTH-1];
      for (int i = 0; i < Q_DEPTH; i++) begin
         if (n_push != 2'd0 && i == int'(base)) q_nxt[i] = push_first;
         if (n_push == 2'd2 && i == int'(base) + 1) q_nxt[i] = push_second;
      end
      cnt_nxt = q_count + CNT_W'(n_push) - CNT_W'(pop);
   end

   // Queue, count, acks, sticky drop flag and priority toggle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q            <= '{default: '0};
         q_count      <= '0;
         live         <= 1'b0;
         prio_b_first <= 1'b0;
         wr_ack_a     <= 1'b0;
         wr_ack_b     <= 1'b0;
         wr_drop      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         q        <= q_nxt;
         q_count  <= cnt_nxt;
         live     <= 1'b1;
         wr_ack_a <= direct_a || (pop && q[0].port == PORT_A);
         wr_ack_b <= direct_b || (pop && q[0].port == PORT_B);
         if (conflict) prio_b_first <= !prio_b_first;
         if ((wr_en_a || wr_en_b) && !ready) wr_drop <= 1'b1;
      end
   end

   // Storage array: head-of-queue commit or direct writes from either port.
   // NOTE: the memory is deliberately not reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (pop)      mem[q[0].addr] <= q[0].data;
      if (direct_a) mem[addr_a]    <= wr_data_a;
      if (direct_b) mem[addr_b]    <= wr_data_b;
   end

   // Combinational reads; the youngest matching pending entry wins.
   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      if (rd_en_a) begin
         rd_data_a = mem[addr_a];
         for (int i = 0; i < Q_DEPTH; i++) begin
            if (i < int'(q_count) && q[i].addr == addr_a) rd_data_a = q[i].data;
         end
      end
      if (rd_en_b) begin
         rd_data_b = mem[addr_b];
         for (int i = 0; i < Q_DEPTH; i++) begin
            if (i < int'(q_count) && q[i].addr == addr_b) rd_data_b = q[i].data;
         end
      end
   end

   // A pop and a direct commit must never land in the same edge.
   ack_unique : assert property (@(posedge clk) disable iff (!reset_n)
                                 !(pop && (direct_a || direct_b)));

endmodule

// File: tb/tb_dualport_ram_cq.sv
// Directed bench for dualport_ram_cq: two instances, PRIO_MODE 0 and 1,
// driven by the same stimulus.
module tb_dualport_ram_cq;
   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 11;
   localparam int Q_DEPTH = 4;
   localparam int CNT_W   = $clog2(Q_DEPTH + 1);

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              wr_en_a, wr_en_b, rd_en_a, rd_en_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] wr_data_a, wr_data_b;

   logic [DATA_W-1:0] rd_data_a, rd_data_b;
   logic              wr_ready_a, wr_ready_b, wr_ack_a, wr_ack_b, wr_drop;
   logic [CNT_W-1:0]  q_count;

   logic [DATA_W-1:0] rd_data_a_p1, rd_data_b_p1;
   logic              wr_ready_a_p1, wr_ready_b_p1, wr_ack_a_p1, wr_ack_b_p1, wr_drop_p1;
   logic [CNT_W-1:0]  q_count_p1;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dualport_ram_cq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Q_DEPTH(Q_DEPTH), .PRIO_MODE(0)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
      .addr_a(addr_a), .addr_b(addr_b), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .wr_ready_a(wr_ready_a), .wr_ready_b(wr_ready_b),
      .wr_ack_a(wr_ack_a), .wr_ack_b(wr_ack_b),
      .q_count(q_count), .wr_drop(wr_drop)
   );

   dualport_ram_cq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Q_DEPTH(Q_DEPTH), .PRIO_MODE(1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
      .addr_a(addr_a), .addr_b(addr_b), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .rd_data_a(rd_data_a_p1), .rd_data_b(rd_data_b_p1),
      .wr_ready_a(wr_ready_a_p1), .wr_ready_b(wr_ready_b_p1),
      .wr_ack_a(wr_ack_a_p1), .wr_ack_b(wr_ack_b_p1),
      .q_count(q_count_p1), .wr_drop(wr_drop_p1)
   );

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
   endtask

   task automatic drive_pair(input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                             input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
      wr_en_a = 1'b1; addr_a = aa; wr_data_a = da;
      wr_en_b = 1'b1; addr_b = ab; wr_data_b = db;
   endtask

   task automatic test_reset();
      #3;
      tests_run++; if (q_count !== 3'd0) begin tests_failed++; $display("FAIL reset q_count: got %0d want 0", q_count); end
      tests_run++; if ({wr_ack_a, wr_ack_b, wr_drop} !== 3'b000) begin tests_failed++; $display("FAIL reset ack/drop: got %b want 000", {wr_ack_a, wr_ack_b, wr_drop}); end
      tests_run++; if (wr_ready_a !== 1'b0) begin tests_failed++; $display("FAIL reset ready: got %b want 0", wr_ready_a); end
      repeat (2) step();
      reset_n = 1'b1;
      tests_run++; if (wr_ready_a !== 1'b0) begin tests_failed++; $display("FAIL first cycle ready: got %b want 0", wr_ready_a); end
      step();
      tests_run++; if ({wr_ready_a, wr_ready_b} !== 2'b11) begin tests_failed++; $display("FAIL ready after release: got %b want 11", {wr_ready_a, wr_ready_b}); end
   endtask

   task automatic test_direct();
      drive_pair(11'h012, 8'h5A, 11'h013, 8'hA5);
      step();
      idle();
      tests_run++; if ({wr_ack_a, wr_ack_b} !== 2'b11) begin tests_failed++; $display("FAIL direct acks: got %b want 11", {wr_ack_a, wr_ack_b}); end
      tests_run++; if (q_count !== 3'd0) begin tests_failed++; $display("FAIL direct q_count: got %0d want 0", q_count); end
      rd_en_a = 1'b1; addr_a = 11'h012;
      rd_en_b = 1'b1; addr_b = 11'h013;
      #1;
      tests_run++; if (rd_data_a !== 8'h5A) begin tests_failed++; $display("FAIL direct read a: got %h want 5a", rd_data_a); end
      tests_run++; if (rd_data_b !== 8'hA5) begin tests_failed++; $display("FAIL direct read b: got %h want a5", rd_data_b); end
      step();
      tests_run++; if ({wr_ack_a, wr_ack_b} !== 2'b00) begin tests_failed++; $display("FAIL direct ack pulse end: got %b want 00", {wr_ack_a, wr_ack_b}); end
      rd_en_a = 1'b0; rd_en_b = 1'b0;
   endtask

   task automatic test_prio1();
      // First conflict: A first in both modes, B's data survives.
      drive_pair(11'h200, 8'h33, 11'h200, 8'h44);
      step();
      idle();
      tests_run++; if (q_count_p1 !== 3'd2) begin tests_failed++; $display("FAIL prio1 q_count: got %0d want 2", q_count_p1); end
      step();
      tests_run++; if ({wr_ack_a_p1, wr_ack_b_p1} !== 2'b10) begin tests_failed++; $display("FAIL prio1 c1 first ack: got %b want 10", {wr_ack_a_p1, wr_ack_b_p1}); end
      step();
      tests_run++; if ({wr_ack_a_p1, wr_ack_b_p1} !== 2'b01) begin tests_failed++; $display("FAIL prio1 c1 second ack: got %b want 01", {wr_ack_a_p1, wr_ack_b_p1}); end
      rd_en_a = 1'b1; addr_a = 11'h200;
      #1;
      tests_run++; if (rd_data_a_p1 !== 8'h44) begin tests_failed++; $display("FAIL prio1 c1 data: got %h want 44", rd_data_a_p1); end
      rd_en_a = 1'b0;
      // Second conflict: mode 1 now pushes B first, so A's data survives.
      drive_pair(11'h200, 8'h55, 11'h200, 8'h66);
      step();
      idle();
      step();
      tests_run++; if ({wr_ack_a_p1, wr_ack_b_p1} !== 2'b01) begin tests_failed++; $display("FAIL prio1 c2 first ack: got %b want 01", {wr_ack_a_p1, wr_ack_b_p1}); end
      step();
      tests_run++; if ({wr_ack_a_p1, wr_ack_b_p1} !== 2'b10) begin tests_failed++; $display("FAIL prio1 c2 second ack: got %b want 10", {wr_ack_a_p1, wr_ack_b_p1}); end
      rd_en_a = 1'b1; addr_a = 11'h200;
      #1;
      tests_run++; if (rd_data_a_p1 !== 8'h55) begin tests_failed++; $display("FAIL prio1 c2 data: got %h want 55", rd_data_a_p1); end
      tests_run++; if (rd_data_a !== 8'h66) begin tests_failed++; $display("FAIL prio0 c2 data: got %h want 66", rd_data_a); end
      rd_en_a = 1'b0;
      step();
   endtask

   task automatic test_conflict();
      drive_pair(11'h100, 8'h11, 11'h100, 8'h22);
      step();
      idle();
      tests_run++; if (q_count !== 3'd2) begin tests_failed++; $display("FAIL conflict q_count push: got %0d want 2", q_count); end
      step();
      tests_run++; if (q_count !== 3'd1) begin tests_failed++; $display("FAIL conflict q_count pop1: got %0d want 1", q_count); end
      tests_run++; if ({wr_ack_a, wr_ack_b} !== 2'b10) begin tests_failed++; $display("FAIL conflict ack first: got %b want 10", {wr_ack_a, wr_ack_b}); end
      step();
      tests_run++; if (q_count !== 3'd0) begin tests_failed++; $display("FAIL conflict q_count pop2: got %0d want 0", q_count); end
      tests_run++; if ({wr_ack_a, wr_ack_b} !== 2'b01) begin tests_failed++; $display("FAIL conflict ack second: got %b want 01", {wr_ack_a, wr_ack_b}); end
      rd_en_b = 1'b1; addr_b = 11'h100;
      #1;
      tests_run++; if (rd_data_b !== 8'h22) begin tests_failed++; $display("FAIL conflict final mem: got %h want 22", rd_data_b); end
      rd_en_b = 1'b0;
      step();
   endtask

   task automatic test_forward();
      drive_pair(11'h300, 8'h11, 11'h300, 8'h22);
      step();
      idle();
      rd_en_a = 1'b1; addr_a = 11'h300;
      #1;
      tests_run++; if (rd_data_a !== 8'h22) begin tests_failed++; $display("FAIL forward youngest: got %h want 22", rd_data_a); end
      tests_run++; if (q_count !== 3'd2) begin tests_failed++; $display("FAIL forward q_count: got %0d want 2", q_count); end
      rd_en_a = 1'b0;
      #1;
      tests_run++; if (rd_data_a !== 8'h00) begin tests_failed++; $display("FAIL forward rd_en low: got %h want 00", rd_data_a); end
      rd_en_a = 1'b1;
      step();
      tests_run++; if (rd_data_a !== 8'h22) begin tests_failed++; $display("FAIL forward one pending: got %h want 22", rd_data_a); end
      rd_en_a = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_backpressure();
      drive_pair(11'h400, 8'h01, 11'h400, 8'h02);
      step();
      tests_run++; if ({q_count, wr_ready_a} !== {3'd2, 1'b1}) begin tests_failed++; $display("FAIL bp edge1 count/ready: got %0d/%b want 2/1", q_count, wr_ready_a); end
      drive_pair(11'h401, 8'h03, 11'h401, 8'h04);
      step();
      idle();
      tests_run++; if ({q_count, wr_ready_a, wr_ready_b} !== {3'd3, 2'b00}) begin tests_failed++; $display("FAIL bp edge2 count/ready: got %0d/%b%b want 3/00", q_count, wr_ready_a, wr_ready_b); end
      tests_run++; if ({wr_ack_a, wr_ack_b, wr_drop} !== 3'b100) begin tests_failed++; $display("FAIL bp edge2 acks/drop: got %b want 100", {wr_ack_a, wr_ack_b, wr_drop}); end
      wr_en_a = 1'b1; addr_a = 11'h402; wr_data_a = 8'h77;
      step();
      idle();
      tests_run++; if ({q_count, wr_drop} !== {3'd2, 1'b1}) begin tests_failed++; $display("FAIL bp drop count/drop: got %0d/%b want 2/1", q_count, wr_drop); end
      tests_run++; if ({wr_ack_a, wr_ack_b} !== 2'b01) begin tests_failed++; $display("FAIL bp edge3 acks: got %b want 01", {wr_ack_a, wr_ack_b}); end
      step();
      tests_run++; if ({q_count, wr_ack_a, wr_ack_b} !== {3'd1, 2'b10}) begin tests_failed++; $display("FAIL bp edge4 count/acks: got %0d/%b%b want 1/10", q_count, wr_ack_a, wr_ack_b); end
      step();
      tests_run++; if ({q_count, wr_ack_a, wr_ack_b} !== {3'd0, 2'b01}) begin tests_failed++; $display("FAIL bp edge5 count/acks: got %0d/%b%b want 0/01", q_count, wr_ack_a, wr_ack_b); end
      step();
      tests_run++; if ({wr_ack_a, wr_ack_b} !== 2'b00) begin tests_failed++; $display("FAIL bp dropped write acked: got %b want 00", {wr_ack_a, wr_ack_b}); end
      rd_en_a = 1'b1; addr_a = 11'h400;
      rd_en_b = 1'b1; addr_b = 11'h401;
      #1;
      tests_run++; if ({rd_data_a, rd_data_b} !== 16'h0204) begin tests_failed++; $display("FAIL bp final mem: got %h want 0204", {rd_data_a, rd_data_b}); end
      rd_en_a = 1'b0; rd_en_b = 1'b0;
   endtask

   task automatic test_async_reset();
      wr_en_a = 1'b1; addr_a = 11'h500; wr_data_a = 8'h99;
      step();
      idle();
      drive_pair(11'h500, 8'hAA, 11'h500, 8'hBB);
      step();
      idle();
      tests_run++; if (q_count !== 3'd2) begin tests_failed++; $display("FAIL areset pre count: got %0d want 2", q_count); end
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++; if ({q_count, wr_ack_a, wr_ack_b, wr_drop} !== 6'd0) begin tests_failed++; $display("FAIL areset outputs: got %0d/%b%b%b want 0/000", q_count, wr_ack_a, wr_ack_b, wr_drop); end
      step();
      rd_en_a = 1'b1; addr_a = 11'h500;
      #1;
      tests_run++; if (rd_data_a !== 8'h99) begin tests_failed++; $display("FAIL areset no commit: got %h want 99", rd_data_a); end
      rd_en_a = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      wr_en_a = 1'b1; addr_a = 11'h501; wr_data_a = 8'h3C;
      step();
      idle();
      tests_run++; if ({wr_ack_a, q_count} !== {1'b1, 3'd0}) begin tests_failed++; $display("FAIL post-reset direct ack/count: got %b/%0d want 1/0", wr_ack_a, q_count); end
      rd_en_a = 1'b1; addr_a = 11'h501;
      #1;
      tests_run++; if (rd_data_a !== 8'h3C) begin tests_failed++; $display("FAIL post-reset read: got %h want 3c", rd_data_a); end
      rd_en_a = 1'b0;
      step();
   endtask

   initial begin
      wr_en_a = 1'b0; wr_en_b = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
      addr_a = '0; addr_b = '0; wr_data_a = '0; wr_data_b = '0;
      test_reset();
      test_direct();
      test_prio1();
      test_conflict();
      test_forward();
      test_backpressure();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
